neuron_mac_unit: RTL and testbench

NEURON_MAC_UNIT -- requirements
Module: neuron_mac_unit

---
 rtl/nn_pkg.sv | 16 +
 rtl/neuron_activation.sv | 37 +++
 rtl/neuron_mac_unit.sv | 146 ++++++++++++++
 tb/tb_neuron_mac_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared defaults and FSM state encoding for the neuron MAC datapath.
package nn_pkg;

  localparam int NN_DATA_W    = 8;
  localparam int NN_ACC_W     = 24;
  localparam int NN_FRAC_BITS = 4;
  localparam int NN_ADDR_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

endpackage

// File: rtl/neuron_activation.sv
// Activation: arithmetic shift by FRAC_BITS, saturate to DATA_W.
// Define NEURON_RELU_EN to additionally clamp negative results to zero.
module neuron_activation
  import nn_pkg::*;
#(
  parameter int DATA_W    = NN_DATA_W,
  parameter int ACC_W     = NN_ACC_W,
  parameter int FRAC_BITS = NN_FRAC_BITS
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [DATA_W-1:0] act_out
);

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat;

  always_comb begin
    shifted = acc_in >>> FRAC_BITS;
    if (shifted > SAT_HI) begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_LO) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat = shifted[DATA_W-1:0];
    end
  end

`ifdef NEURON_RELU_EN
  assign act_out = sat[DATA_W-1] ? '0 : sat;
`else
  assign act_out = sat;
`endif

endmodule

// File: rtl/neuron_mac_unit.sv
// Layer MAC sequencer: accumulates weight*activation per neuron and writes act(sum).
// Optional ReLU clamp selected by NEURON_RELU_EN (see neuron_activation).
//
// state    | meaning
// ST_IDLE  | waiting for start; ag_load follows start
// ST_RUN   | address generator streaming operands
// ST_DRAIN | last operand in flight, final write pending
// ST_DONE  | one-cycle done pulse, then back to idle
module neuron_mac_unit
  import nn_pkg::*;
#(
  parameter int DATA_W    = NN_DATA_W,
  parameter int ACC_W     = NN_ACC_W,
  parameter int FRAC_BITS = NN_FRAC_BITS,
  parameter int ADDR_W    = NN_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     ag_load,
  input  logic                     neuron_finished,
  input  logic                     finished,
  input  logic [ADDR_W-1:0]        neuro_write_addr,
  input  logic signed [DATA_W-1:0] weight_data,
  input  logic signed [DATA_W-1:0] neuro_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done
);

  mac_state_e state_q, state_d;

  logic                     vld_q, vld_d;
  logic                     nf_q, nf_d;
  logic                     fin_q, fin_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic signed [DATA_W-1:0] wr_data_q, wr_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic signed [DATA_W-1:0]   act_val;

  assign prod     = weight_data * neuro_data;
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc_q + prod_ext;

  neuron_activation #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_act (
    .acc_in  (sum),
    .act_out (act_val)
  );

  assign ag_load = reset && (state_q == ST_IDLE) && start;

  always_comb begin
    state_d   = state_q;
    vld_d     = 1'b0;
    nf_d      = 1'b0;
    fin_d     = 1'b0;
    addr_d    = addr_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    // Address-phase strobes are delayed one cycle to line up with returning data.
    if (state_q == ST_RUN) begin
      vld_d  = 1'b1;
      nf_d   = neuron_finished;
      fin_d  = finished;
      addr_d = neuro_write_addr;
    end

    if (vld_q) begin
      if (nf_q) begin
        acc_d     = '0;
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = act_val;
      end else begin
        acc_d = sum;
      end
    end

    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (finished) state_d = ST_DRAIN;
      // fin_q drops once the last operand has been consumed; its write is then registered.
      ST_DRAIN: if (!fin_q) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      vld_q     <= 1'b0;
      nf_q      <= 1'b0;
      fin_q     <= 1'b0;
      addr_q    <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      nf_q      <= nf_d;
      fin_q     <= fin_d;
      addr_q    <= addr_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Bench for neuron_mac_unit: the bench plays the address generator and
// compares every write/done/ag_load against a plain-arithmetic layer model.
module tb_neuron_mac_unit;

  localparam int DATA_W    = 8;
  localparam int ACC_W     = 24;
  localparam int FRAC_BITS = 4;
  localparam int ADDR_W    = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     ag_load;
  logic                     neuron_finished;
  logic                     finished;
  logic [ADDR_W-1:0]        neuro_write_addr;
  logic signed [DATA_W-1:0] weight_data;
  logic signed [DATA_W-1:0] neuro_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     busy;
  logic                     done;

  neuron_mac_unit #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .ag_load          (ag_load),
    .neuron_finished  (neuron_finished),
    .finished         (finished),
    .neuro_write_addr (neuro_write_addr),
    .weight_data      (weight_data),
    .neuro_data       (neuro_data),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wr_q[$];
  wr_t exp_q[$];
  int  done_q[$];
  int  ag_q[$];
  int  busy_n;

  // Outputs are observed mid-cycle; inputs change just after the rising edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) wr_q.push_back('{cyc, int'(wr_addr), int'(wr_data)});
    if (done === 1'b1) done_q.push_back(cyc);
    if (ag_load === 1'b1) ag_q.push_back(cyc);
    if (busy === 1'b1) busy_n++;
  end

  function automatic int ref_act(input longint s);
    longint w;
    longint sh;
    w = s % 16777216;
    if (w >= 8388608) w -= 16777216;
    if (w < -8388608) w += 16777216;
    sh = w >>> FRAC_BITS;
    if (sh > 127) sh = 127;
    if (sh < -128) sh = -128;
`ifdef NEURON_RELU_EN
    if (sh < 0) sh = 0;
`endif
    return int'(sh);
  endfunction

  int n_neu;
  int n_in[8];
  int nadr[8];
  int wt[8][8];
  int xv[8][8];

  task automatic run_layer(input string name, input int mid_start, input int abort_at);
    int  t0, k, tot, last_cyc, pw, px;
    bit  have_p, aborted;
    longint acc;
    wr_q.delete();
    exp_q.delete();
    done_q.delete();
    ag_q.delete();
    busy_n   = 0;
    tot      = 0;
    last_cyc = 0;
    pw       = 0;
    px       = 0;
    for (int n = 0; n < n_neu; n++) tot += n_in[n];

    start = 1'b1;
    t0    = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    k       = 0;
    have_p  = 1'b0;
    aborted = 1'b0;
    for (int n = 0; n < n_neu && !aborted; n++) begin
      acc = 0;
      for (int i = 0; i < n_in[n] && !aborted; i++) begin
        if (k == abort_at) begin
          reset           = 1'b0;
          start           = 1'b1;
          neuron_finished = 1'b0;
          finished        = 1'b0;
          weight_data     = '0;
          neuro_data      = '0;
          @(posedge clk); #1;
          check_val({name, ":busy_after_rst"}, busy, 0);
          check_val({name, ":wr_en_after_rst"}, wr_en, 0);
          check_val({name, ":done_after_rst"}, done, 0);
          check_val({name, ":ag_load_in_rst"}, ag_load, 0);
          reset   = 1'b1;
          start   = 1'b0;
          aborted = 1'b1;
        end else begin
          weight_data      = have_p ? DATA_W'(pw) : '0;
          neuro_data       = have_p ? DATA_W'(px) : '0;
          neuron_finished  = (i == n_in[n] - 1);
          finished         = (k == tot - 1);
          neuro_write_addr = ADDR_W'(nadr[n]);
          start            = (k == mid_start);
          acc += longint'(wt[n][i] * xv[n][i]);
          pw     = wt[n][i];
          px     = xv[n][i];
          have_p = 1'b1;
          if (i == n_in[n] - 1) exp_q.push_back('{cyc + 2, nadr[n], ref_act(acc)});
          last_cyc = cyc;
          @(posedge clk); #1;
          k++;
        end
      end
    end
    if (!aborted) begin
      weight_data     = DATA_W'(pw);
      neuro_data      = DATA_W'(px);
      neuron_finished = 1'b0;
      finished        = 1'b0;
      start           = 1'b0;
      @(posedge clk); #1;
    end
    weight_data = '0;
    neuro_data  = '0;
    repeat (8) @(posedge clk);
    #1;

    check_val({name, ":n_wr"}, wr_q.size(), exp_q.size());
    for (int j = 0; j < wr_q.size() && j < exp_q.size(); j++) begin
      check_val({name, ":wr_cyc"}, wr_q[j].cyc, exp_q[j].cyc);
      check_val({name, ":wr_addr"}, wr_q[j].addr, exp_q[j].addr);
      check_val({name, ":wr_data"}, wr_q[j].data, exp_q[j].data);
    end
    check_val({name, ":n_done"}, done_q.size(), aborted ? 0 : 1);
    if (!aborted && done_q.size() > 0)
      check_val({name, ":done_cyc"}, done_q[0], last_cyc + 3);
    check_val({name, ":n_ag_load"}, ag_q.size(), 1);
    if (ag_q.size() > 0) check_val({name, ":ag_load_cyc"}, ag_q[0], t0);
    if (!aborted) check_val({name, ":busy_cycles"}, busy_n, last_cyc + 3 - t0);
  endtask

  task automatic set_uniform(input int nn, input int ni, input int a0, input int w, input int x);
    n_neu = nn;
    for (int n = 0; n < nn; n++) begin
      n_in[n] = ni;
      nadr[n] = a0 + n;
      for (int i = 0; i < ni; i++) begin
        wt[n][i] = w;
        xv[n][i] = x;
      end
    end
  endtask

  task automatic set_random(input int max_neu, input int max_in);
    n_neu = int'($urandom_range(1, max_neu));
    for (int n = 0; n < n_neu; n++) begin
      n_in[n] = int'($urandom_range(1, max_in));
      nadr[n] = int'($urandom_range(0, 255));
      for (int i = 0; i < n_in[n]; i++) begin
        wt[n][i] = int'($urandom_range(0, 255)) - 128;
        xv[n][i] = int'($urandom_range(0, 255)) - 128;
      end
    end
  endtask

  initial begin
    reset            = 1'b0;
    start            = 1'b1;
    neuron_finished  = 1'b1;
    finished         = 1'b1;
    neuro_write_addr = 8'hA5;
    weight_data      = 8'sd77;
    neuro_data       = -8'sd9;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst:wr_en", wr_en, 0);
    check_val("rst:wr_addr", wr_addr, 0);
    check_val("rst:wr_data", wr_data, 0);
    check_val("rst:done", done, 0);
    check_val("rst:busy", busy, 0);
    check_val("rst:ag_load", ag_load, 0);
    reset           = 1'b1;
    start           = 1'b0;
    neuron_finished = 1'b0;
    finished        = 1'b0;
    weight_data     = '0;
    neuro_data      = '0;
    @(posedge clk); #1;

    set_uniform(1, 2, 5, 16, 32);
    run_layer("two_in", -1, -1);
    check_val("two_in:lit", (wr_q.size() > 0) ? wr_q[0].data : -999, 64);

    set_uniform(1, 3, 7, 127, 127);
    run_layer("sat_hi", -1, -1);
    check_val("sat_hi:lit", (wr_q.size() > 0) ? wr_q[0].data : -999, 127);

    set_uniform(1, 1, 9, -16, 32);
    run_layer("neg_one", -1, -1);
`ifdef NEURON_RELU_EN
    check_val("neg_one:lit", (wr_q.size() > 0) ? wr_q[0].data : -999, 0);
`else
    check_val("neg_one:lit", (wr_q.size() > 0) ? wr_q[0].data : -999, -32);
`endif

    set_uniform(3, 2, 10, 20, 13);
    run_layer("three_neu", -1, -1);
    if (wr_q.size() == 3) begin
      check_val("three_neu:same01", wr_q[1].data, wr_q[0].data);
      check_val("three_neu:same12", wr_q[2].data, wr_q[1].data);
    end

    set_uniform(3, 2, 10, 20, 13);
    run_layer("mid_start", 1, -1);

    set_uniform(1, 4, 3, 50, 60);
    run_layer("abort", -1, 2);

    set_uniform(1, 2, 5, 16, 32);
    run_layer("after_abort", -1, -1);

    n_neu = 6;
    for (int n = 0; n < n_neu; n++) begin
      n_in[n]  = 1;
      nadr[n]  = 40 + n;
      wt[n][0] = int'($urandom_range(0, 255)) - 128;
      xv[n][0] = int'($urandom_range(0, 255)) - 128;
    end
    run_layer("one_per_neu", -1, -1);

    for (int r = 0; r < 20; r++) begin
      set_random(6, 5);
      run_layer($sformatf("rand%0d", r), (r % 4 == 1) ? 2 : -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
